// File: rtl/div_unit_pkg.sv
// Shared definitions for the fixed-point divider lane: op decode constants,
// FSM state encoding and format helpers.
package div_unit_pkg;

  localparam logic [3:0] OP_ALU = 4'b0000;
  localparam logic [3:0] FN_DIV = 4'b0100;

  // Upper bound on supported operand width for the saturation-limit helpers.
  localparam int unsigned MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic [MAX_W-1:0] max_pos(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < w - 1; i++) begin
      r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] max_neg(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

  // Clamp the signed format-alignment shift into [0, w].
  function automatic int unsigned clamp_shift(input logic signed [10:0] s,
                                              input int unsigned w);
    int v;
    v = int'(s);
    if (v < 0) begin
      return 0;
    end
    if (v > int'(w)) begin
      return w;
    end
    return unsigned'(v);
  endfunction

endpackage

// File: rtl/div_unit_core.sv
// Restoring unsigned 2W/W divider: one quotient bit per clock, 2W clocks per
// operation, quotient held after completion until the next start.
module div_core #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           last,
  output logic [2*W-1:0] quotient
);

  localparam int unsigned CW = $clog2(2 * W);

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rem;
  logic [W-1:0]   dvsr;
  logic [2*W-1:0] quo;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic           ge;

  // rem < dvsr keeps rem_sh below 2*dvsr, so the borrow bit alone decides.
  always_comb begin
    rem_sh = {rem, quo[2*W-1]};
    diff   = rem_sh - {1'b0, dvsr};
    ge     = ~diff[W];
  end

  assign last     = busy && (cnt == CW'(2 * W - 1));
  assign quotient = quo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dvsr <= '0;
      quo  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      dvsr <= divisor;
      quo  <= dividend;
    end else if (busy) begin
      rem <= ge ? diff[W-1:0] : rem_sh[W-1:0];
      quo <= {quo[2*W-2:0], ge};
      cnt <= cnt + CW'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/div_unit.sv
// Signed fixed-point divider lane with valid/ready handshake; owns format
// alignment, sign handling and saturation around the iterative div_core.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned OPCODE_BITS   = 4,
  parameter int unsigned FUNCTION_BITS = 4,
  parameter int unsigned BIT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_BITS-1:0]   opcode,
  input  logic [FUNCTION_BITS-1:0] fn,
  input  logic [BIT_WIDTH-1:0]     data_in0,
  input  logic [BIT_WIDTH-1:0]     data_in1,
  input  logic [7:0]               dest_integer_bits,
  input  logic [7:0]               src1_integer_bits,
  input  logic [7:0]               src2_integer_bits,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_WIDTH-1:0]     data_out,
  output logic                     div_by_zero,
  output logic                     saturated
);

  localparam int unsigned W = BIT_WIDTH;

  localparam logic [MAX_W-1:0] MAX_POS_WIDE = max_pos(W);
  localparam logic [MAX_W-1:0] MAX_NEG_WIDE = max_neg(W);
  localparam logic [W-1:0]     MAX_POS      = MAX_POS_WIDE[W-1:0];
  localparam logic [W-1:0]     MAX_NEG      = MAX_NEG_WIDE[W-1:0];
  localparam logic [2*W-1:0]   LIM_POS      = {{W{1'b0}}, MAX_POS};
  localparam logic [2*W-1:0]   LIM_NEG      = {{W{1'b0}}, MAX_NEG};

  state_t state, state_nxt;

  logic                accept;
  logic                is_div_in;
  logic                b_zero_in;
  logic                start;
  logic signed [10:0]  s_raw;
  int unsigned         sh;
  logic [W:0]          a_ext;
  logic [W:0]          a_abs;
  logic [W-1:0]        b_abs;
  logic [2*W-1:0]      dividend;
  logic                core_last;
  logic [2*W-1:0]      q;

  logic                is_div_q;
  logic                dbz_q;
  logic                neg_q;
  logic                a_neg_q;
  logic [W-1:0]        a_q;

  logic [W-1:0]        res_data;
  logic                res_dbz;
  logic                res_sat;

  always_comb begin
    accept    = in_valid && in_ready;
    is_div_in = (opcode == OPCODE_BITS'(OP_ALU)) && (fn == FUNCTION_BITS'(FN_DIV));
    b_zero_in = (data_in1 == '0);
    start     = accept && is_div_in && !b_zero_in;
    s_raw     = 11'(W) - {3'b000, dest_integer_bits}
              + {3'b000, src1_integer_bits} - {3'b000, src2_integer_bits};
    sh        = clamp_shift(s_raw, W);
    // One extra bit so the most negative dividend has a representable magnitude.
    a_ext     = {data_in0[W-1], data_in0};
    a_abs     = a_ext[W] ? (~a_ext + (W + 1)'(1)) : a_ext;
    b_abs     = data_in1[W-1] ? (~data_in1 + W'(1)) : data_in1;
    dividend  = {{(W - 1){1'b0}}, a_abs} << sh;
  end

  div_core #(
    .W (W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (b_abs),
    .last     (core_last),
    .quotient (q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = start ? CALC : FIX;
      CALC: if (core_last) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_comb begin
    res_data = q[W-1:0];
    res_dbz  = 1'b0;
    res_sat  = 1'b0;
    if (!is_div_q) begin
      res_data = a_q;
    end else if (dbz_q) begin
      res_data = a_neg_q ? MAX_NEG : MAX_POS;
      res_dbz  = 1'b1;
    end else if (neg_q) begin
      if (q > LIM_NEG) begin
        res_data = MAX_NEG;
        res_sat  = 1'b1;
      end else begin
        res_data = ~q[W-1:0] + W'(1);
      end
    end else if (q > LIM_POS) begin
      res_data = MAX_POS;
      res_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_div_q    <= 1'b0;
      dbz_q       <= 1'b0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      a_q         <= '0;
      data_out    <= '0;
      div_by_zero <= 1'b0;
      saturated   <= 1'b0;
    end else if (accept) begin
      is_div_q    <= is_div_in;
      dbz_q       <= b_zero_in;
      neg_q       <= data_in0[W-1] ^ data_in1[W-1];
      a_neg_q     <= data_in0[W-1];
      a_q         <= data_in0;
      div_by_zero <= 1'b0;
      saturated   <= 1'b0;
    end else if (state == FIX) begin
      data_out    <= res_data;
      div_by_zero <= res_dbz;
      saturated   <= res_sat;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit at W=32: result, flags and latency per
// vector, plus backpressure and mid-operation reset sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  fn;
  logic [31:0] data_in0;
  logic [31:0] data_in1;
  logic [7:0]  dest_integer_bits;
  logic [7:0]  src1_integer_bits;
  logic [7:0]  src2_integer_bits;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        div_by_zero;
  logic        saturated;

  always #5 clk = ~clk;

  div_unit #(
    .OPCODE_BITS   (4),
    .FUNCTION_BITS (4),
    .BIT_WIDTH     (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .opcode            (opcode),
    .fn                (fn),
    .data_in0          (data_in0),
    .data_in1          (data_in1),
    .dest_integer_bits (dest_integer_bits),
    .src1_integer_bits (src1_integer_bits),
    .src2_integer_bits (src2_integer_bits),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .data_out          (data_out),
    .div_by_zero       (div_by_zero),
    .saturated         (saturated)
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  di;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [31:0] exp;
    logic        dbz;
    logic        sat;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] f,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] di, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [31:0] exp, input logic dbz, input logic sat,
                              input int lat);
    vec_t v;
    v.op = op; v.fn = f; v.a = a; v.b = b;
    v.di = di; v.s1 = s1; v.s2 = s2;
    v.exp = exp; v.dbz = dbz; v.sat = sat; v.lat = lat;
    return v;
  endfunction

  // Applies one operation, scrambles the inputs right after the accept edge,
  // counts edges until out_valid, then completes the output handshake.
  task automatic do_op(input vec_t v, output logic [31:0] d, output logic z,
                       output logic s, output int lat);
    @(negedge clk);
    opcode = v.op; fn = v.fn; data_in0 = v.a; data_in1 = v.b;
    dest_integer_bits = v.di; src1_integer_bits = v.s1; src2_integer_bits = v.s2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode = ~v.op; fn = ~v.fn; data_in0 = ~v.a; data_in1 = ~v.b;
    dest_integer_bits = 8'hA5; src1_integer_bits = 8'h5A; src2_integer_bits = 8'h33;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
    d = data_out;
    z = div_by_zero;
    s = saturated;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] d_r;
  logic        z_r;
  logic        s_r;
  int          lat_r;

  initial begin
    vecs[0]  = mk(4'h0, 4'h4, 32'h0006_0000, 32'h0002_0000, 8'd16, 8'd16, 8'd16, 32'h0003_0000, 1'b0, 1'b0, 65);
    vecs[1]  = mk(4'h0, 4'h4, 32'hFFF8_8000, 32'h0002_0000, 8'd16, 8'd16, 8'd16, 32'hFFFC_4000, 1'b0, 1'b0, 65);
    vecs[2]  = mk(4'h0, 4'h4, 32'hFFFF_FFF9, 32'h0000_0002, 8'd32, 8'd32, 8'd32, 32'hFFFF_FFFD, 1'b0, 1'b0, 65);
    vecs[3]  = mk(4'h0, 4'h4, 32'h7FFF_0000, 32'h0000_0100, 8'd16, 8'd16, 8'd16, 32'h7FFF_FFFF, 1'b0, 1'b1, 65);
    vecs[4]  = mk(4'h0, 4'h4, 32'h8000_0000, 32'hFFFF_0000, 8'd16, 8'd16, 8'd16, 32'h7FFF_FFFF, 1'b0, 1'b1, 65);
    vecs[5]  = mk(4'h0, 4'h4, 32'h8000_0000, 32'h0000_0000, 8'd16, 8'd16, 8'd16, 32'h8000_0000, 1'b1, 1'b0, 1);
    vecs[6]  = mk(4'h0, 4'h4, 32'h0000_0000, 32'h0000_0000, 8'd16, 8'd16, 8'd16, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    vecs[7]  = mk(4'h1, 4'h4, 32'h1234_5678, 32'h0000_0003, 8'd16, 8'd16, 8'd16, 32'h1234_5678, 1'b0, 1'b0, 1);
    vecs[8]  = mk(4'h0, 4'h4, 32'h0000_0000, 32'h0000_0005, 8'd16, 8'd16, 8'd16, 32'h0000_0000, 1'b0, 1'b0, 65);
    vecs[9]  = mk(4'h0, 4'h5, 32'hDEAD_BEEF, 32'h0000_0000, 8'd16, 8'd16, 8'd16, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
    vecs[10] = mk(4'h0, 4'h4, 32'h0007_0000, 32'hFFFE_0000, 8'd16, 8'd16, 8'd16, 32'hFFFC_8000, 1'b0, 1'b0, 65);
    vecs[11] = mk(4'h0, 4'h4, 32'h7FFF_0000, 32'hFFFF_FF00, 8'd16, 8'd16, 8'd16, 32'h8000_0000, 1'b0, 1'b1, 65);
    vecs[12] = mk(4'h0, 4'h4, 32'h8000_0000, 32'h0000_0001, 8'd32, 8'd32, 8'd32, 32'h8000_0000, 1'b0, 1'b0, 65);
    vecs[13] = mk(4'h0, 4'h4, 32'h0000_0064, 32'h0000_0007, 8'd255, 8'd0, 8'd0, 32'h0000_000E, 1'b0, 1'b0, 65);
    vecs[14] = mk(4'h0, 4'h4, 32'h0000_0001, 32'h0000_0004, 8'd0, 8'd32, 8'd0, 32'h4000_0000, 1'b0, 1'b0, 65);

    in_valid = 1'b0; out_ready = 1'b0; opcode = '0; fn = '0;
    data_in0 = '0; data_in1 = '0;
    dest_integer_bits = '0; src1_integer_bits = '0; src2_integer_bits = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #20;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_flags", {30'b0, div_by_zero, saturated}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i], d_r, z_r, s_r, lat_r);
      check($sformatf("vec%0d_data", i), d_r, vecs[i].exp);
      check($sformatf("vec%0d_dbz", i), {31'b0, z_r}, {31'b0, vecs[i].dbz});
      check($sformatf("vec%0d_sat", i), {31'b0, s_r}, {31'b0, vecs[i].sat});
      check($sformatf("vec%0d_lat", i), 32'(lat_r), 32'(vecs[i].lat));
      check($sformatf("vec%0d_idle", i), {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Bypass result held under backpressure.
    @(negedge clk);
    opcode = 4'h1; fn = 4'h0; data_in0 = 32'h1234_5678; data_in1 = 32'h0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in0 = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    check("hold_first_valid", {31'b0, out_valid}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid_ready", c), {30'b0, out_valid, in_ready}, 32'd2);
      check($sformatf("hold%0d_data", c), data_out, 32'h1234_5678);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);

    // Reset during CALC abandons the operation immediately.
    @(negedge clk);
    opcode = 4'h0; fn = 4'h4; data_in0 = 32'h0006_0000; data_in1 = 32'h0002_0000;
    dest_integer_bits = 8'd16; src1_integer_bits = 8'd16; src2_integer_bits = 8'd16;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("calc_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    check("midrst_flags", {30'b0, div_by_zero, saturated}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_output", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(vecs[0], d_r, z_r, s_r, lat_r);
    check("postrst_data", d_r, 32'h0003_0000);
    check("postrst_lat", 32'(lat_r), 32'd65);
    check("postrst_sat", {31'b0, s_r}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle signed fixed-point divider lane for the SIMD datapath, sitting alongside the multiply/MAC lane.
- It performs the inverse operation of the multiply lane: quotient = data_in0 / data_in1, with per-operand integer-bit formats, truncation toward zero and saturation to BIT_WIDTH.
- Uses a valid/ready handshake on both input and output, because its latency (2*BIT_WIDTH+1 cycles) is not fixed-single-cycle.

Parameters:
- OPCODE_BITS, 4, opcode field width
- FUNCTION_BITS, 4, function field width
- BIT_WIDTH, 32, operand/result width (W); even, >= 8

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept (high only in IDLE)
- opcode  in  OPCODE_BITS  operation class
- fn  in  FUNCTION_BITS  function code
- data_in0  in  W  signed dividend
- data_in1  in  W  signed divisor
- dest_integer_bits  in  8  integer bits of result format
- src1_integer_bits  in  8  integer bits of dividend format
- src2_integer_bits  in  8  integer bits of divisor format
- out_valid  out  1  data_out valid, held until out_ready
- out_ready  in  1  consumer accepts result
- data_out  out  W  signed result (registered)
- div_by_zero  out  1  sticky per result: divisor was 0
- saturated  out  1  per result: quotient clipped

Behaviour:
- Reset: asynchronous on reset=0. State=IDLE; in_ready=1; out_valid, data_out, div_by_zero, saturated=0; all internal registers cleared. Reset mid-operation abandons the operation and produces no output.
- Accept: on an edge with in_valid & in_ready (edge 0). All inputs are captured on this edge; later input changes are ignored.
- Ops:
  - opcode=0000, fn=0100: DIV.
  - All other opcode/fn combinations: BYPASS, data_out=data_in0.
- Shift: s = W - dest_integer_bits + src1_integer_bits - src2_integer_bits, computed signed 11-bit. s is clamped to [0, W]. N = |A| << s (2W bits). Quotient Q = floor(N / |B|) (2W bits).
- Sign and saturation: Q is negated if sign(A) != sign(B).
  - If the signed result exceeds the range: positive clips to 0x7FF..F, negative clips to 0x80..0, and saturated=1.
  - |A| is computed in W+1 bits, so the minimum negative value is handled.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE → CALC on accepting a DIV with B != 0; iteration counter is set to 0.
  - IDLE → FIX on accepting BYPASS or a DIV with B == 0.
  - CALC: one restoring shift/subtract step per edge (one quotient bit per edge). After 2W steps (edges 1..2W), CALC → FIX.
  - FIX: apply sign and saturation, register data_out and flags, set out_valid. FIX → DONE.
  - DONE: hold data_out, out_valid=1. On out_ready, DONE → IDLE and out_valid drops on that edge.
- Latency from the accepting edge:
  - out_valid rises after edge 2W+1 for a normal DIV.
  - out_valid rises after edge 1 for BYPASS and divide-by-zero.
- Back-to-back: the next accept is possible on the edge after the result handshake. There is no overlap; in_ready=0 from CALC through DONE.
- Divide by zero: data_out = 0x7FF..F if A >= 0 (including 0/0), or 0x80..0 if A < 0. div_by_zero=1, saturated=0.
- A=0 with B!=0: runs the full latency; data_out=0.
- Flags are cleared on the next accept.

Decomposition:
- Shared package holds:
  - opcode/fn constants (OP_ALU=0000, FN_DIV=0100)
  - state enum (IDLE/CALC/FIX/DONE)
  - MAX_POS/MAX_NEG functions of W
  - shift-clamp helper
- Natural sub-module: div_core. It is the restoring iterative unsigned 2W/W divider with start/done, plus a remainder/quotient shift register and counter. The top-level div_unit owns the handshake, format shift, sign and saturation.

Test Plan (W=32):
- Q16.16 (all integer_bits=16, s=16), A=0x00060000, B=0x00020000 → data_out=0x00030000, out_valid exactly 65 edges after accept, saturated=0.
- Q16.16, A=0xFFF88000 (-7.5), B=0x00020000 (2.0) → data_out=0xFFFC4000 (-3.75). Repeat with -7 / 2 in Q32.0 (dest/src1/src2 integer_bits=32, s=W-32+32-32=0) → 0xFFFFFFFD (truncation toward zero).
- Q16.16, A=0x7FFF0000, B=0x00000100 → data_out=0x7FFFFFFF, saturated=1. A=0x80000000, B=0xFFFF0000 (-1.0) → 0x7FFFFFFF, saturated=1.
- DIV with B=0: A=0x80000000 → 0x80000000; A=0 → 0x7FFFFFFF. Both have div_by_zero=1 and out_valid after edge 1.
- BYPASS: opcode=0001, data_in0=0x12345678 → data_out=0x12345678 after edge 1. Hold out_ready=0 for 10 cycles → out_valid and data_out stable, in_ready=0. Release → in_ready=1 next cycle.
- Assert reset at CALC iteration 20 → all outputs 0, in_ready=1 immediately (async). Deassert and issue the first test again → correct result and latency.
